mc_ctrl_fsm: RTL and testbench

- Multi-cycle control unit placed directly upstream of the MIPS datapath.
- Consumes the decoded opcode, funct and bit16 fields and sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states.
- Drives every datapath control input, plus PCWrite/IRWrite enables for the multi-cycle PC and IR registers.
- Replaces purely combinational decode so that each write enable is a single-cycle, state-qualified pulse.

---
 rtl/mc_ctrl_fsm_if.sv | 37 +++
 rtl/mc_ctrl_fsm.sv | 209 ++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle control FSM (master) and the MIPS datapath (slave).
// The datapath supplies the decoded instruction fields; the FSM returns every control strobe and select.
interface mc_ctrl_fsm_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       bit16;
   logic       PCWrite;
   logic       IRWrite;
   logic       RegWrite;
   logic [1:0] RwIdSrc;
   logic [1:0] RwDataSrc;
   logic       MemRead;
   logic       MemWrite;
   logic       MemOpType;
   logic       MemDataExtType;
   logic [2:0] BranchType;
   logic [1:0] JumpType;
   logic [4:0] AluCtr;
   logic [1:0] AluBSrc;
   logic       ExtType;
   logic       instr_done;
   logic       illegal;

   modport master (
      input  opcode, funct, bit16,
      output PCWrite, IRWrite, RegWrite, RwIdSrc, RwDataSrc, MemRead, MemWrite,
             MemOpType, MemDataExtType, BranchType, JumpType, AluCtr, AluBSrc,
             ExtType, instr_done, illegal
   );

   modport slave (
      output opcode, funct, bit16,
      input  PCWrite, IRWrite, RegWrite, RwIdSrc, RwDataSrc, MemRead, MemWrite,
             MemOpType, MemDataExtType, BranchType, JumpType, AluCtr, AluBSrc,
             ExtType, instr_done, illegal
   );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB, state-qualified single-cycle write pulses.
// Latency: branch/jump 3, ALU/store 4, load 5 cycles; no backpressure, the datapath always keeps pace.
// MC_CTRL_ILLEGAL_TRAP_EN: unknown instructions halt with sticky illegal; otherwise they retire as NOPs.
module mc_ctrl_fsm #(
   parameter logic [2:0] RESET_STATE = 3'd0
) (
   input  logic          clk,
   input  logic          rst,
   mc_ctrl_fsm_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_e;

   typedef enum logic [1:0] {K_ALU, K_LOAD, K_STORE, K_CTL} kind_e;

   typedef struct packed {
      kind_e      kind;
      logic [4:0] alu;
      logic [1:0] bsrc;
      logic       ext;
      logic       memop;
      logic       memext;
      logic [2:0] bt;
      logic [1:0] jt;
      logic [1:0] rwid;
      logic [1:0] rwdata;
      logic       link;
   } dec_t;

   // Unknown encodings fall out as K_CTL with all-zero controls, i.e. a PC-advancing NOP.
   function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn, input logic b16);
      dec_t d;
      d = '0;
      d.kind = K_CTL;
      case (op)
         6'b000000: begin
            d.kind = K_ALU;
            d.rwid = 2'b01;
            case (fn)
               6'b100001: d.alu = 5'd0;
               6'b100011: d.alu = 5'd1;
               6'b100100: d.alu = 5'd2;
               6'b100101: d.alu = 5'd3;
               6'b101010: d.alu = 5'd4;
               6'b000000: d.alu = 5'd5;
               6'b001000: begin d.kind = K_CTL; d.rwid = 2'b00; d.jt = 2'b11; end
               default:   begin d.kind = K_CTL; d.rwid = 2'b00; end
            endcase
         end
         6'b001001: begin d.kind = K_ALU; d.bsrc = 2'b01; d.ext = 1'b1; end
         6'b001101: begin d.kind = K_ALU; d.alu = 5'd3; d.bsrc = 2'b01; end
         6'b001111: begin d.kind = K_ALU; d.alu = 5'd3; d.bsrc = 2'b11; end
         6'b100011: begin d.kind = K_LOAD; d.bsrc = 2'b01; d.ext = 1'b1; d.rwdata = 2'b01; end
         6'b100000: begin
            d.kind = K_LOAD; d.bsrc = 2'b01; d.ext = 1'b1; d.rwdata = 2'b01;
            d.memop = 1'b1; d.memext = 1'b1;
         end
         6'b101011: begin d.kind = K_STORE; d.bsrc = 2'b01; d.ext = 1'b1; end
         6'b101000: begin d.kind = K_STORE; d.bsrc = 2'b01; d.ext = 1'b1; d.memop = 1'b1; end
         6'b000100: begin d.alu = 5'd1; d.bt = 3'b001; end
         6'b000101: begin d.alu = 5'd1; d.bt = 3'b010; end
         6'b000001: begin d.bsrc = 2'b10; d.bt = b16 ? 3'b110 : 3'b101; end
         6'b000010: d.jt = 2'b01;
         6'b000011: begin d.jt = 2'b10; d.link = 1'b1; d.rwid = 2'b10; d.rwdata = 2'b10; end
         default: ;
      endcase
      return d;
   endfunction

   state_e     state_q, state_d;
   logic [5:0] op_q, fn_q;
   logic       b16_q;
   dec_t       dec_q;
   logic       pc_wr, ir_wr, reg_wr, mem_rd, mem_wr, done;

   assign dec_q = decode(op_q, fn_q, b16_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= state_e'(RESET_STATE);
         op_q    <= '0;
         fn_q    <= '0;
         b16_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q  <= bus.opcode;
            fn_q  <= bus.funct;
            b16_q <= bus.bit16;
         end
      end
   end

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   function automatic logic known(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b000000: return fn inside {6'b100001, 6'b100011, 6'b100100, 6'b100101,
                                      6'b101010, 6'b000000, 6'b001000};
         6'b001001, 6'b001101, 6'b001111, 6'b100011, 6'b100000, 6'b101011,
         6'b101000, 6'b000100, 6'b000101, 6'b000001, 6'b000010, 6'b000011: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   logic illegal_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_q <= 1'b0;
      end else if (state_q == S_DECODE && !known(bus.opcode, bus.funct)) begin
         illegal_q <= 1'b1;
      end
   end

   assign bus.illegal = illegal_q;
`else
   assign bus.illegal = 1'b0;
`endif

   always_comb begin
      state_d            = state_q;
      pc_wr              = 1'b0;
      ir_wr              = 1'b0;
      reg_wr             = 1'b0;
      mem_rd             = 1'b0;
      mem_wr             = 1'b0;
      done               = 1'b0;
      bus.RwIdSrc        = 2'b00;
      bus.RwDataSrc      = 2'b00;
      bus.MemOpType      = 1'b0;
      bus.MemDataExtType = 1'b0;
      bus.BranchType     = 3'b000;
      bus.JumpType       = 2'b00;
      bus.AluCtr         = 5'd0;
      bus.AluBSrc        = 2'b00;
      bus.ExtType        = 1'b0;

      // Selects stay stable for the whole execute/memory/write-back window.
      if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
         bus.RwIdSrc        = dec_q.rwid;
         bus.RwDataSrc      = dec_q.rwdata;
         bus.MemOpType      = dec_q.memop;
         bus.MemDataExtType = dec_q.memext;
         bus.AluCtr         = dec_q.alu;
         bus.AluBSrc        = dec_q.bsrc;
         bus.ExtType        = dec_q.ext;
      end

      case (state_q)
         S_FETCH: begin
            ir_wr   = 1'b1;
            state_d = S_DECODE;
         end
         S_DECODE: begin
            state_d = S_EXEC;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            if (!known(bus.opcode, bus.funct)) state_d = S_HALT;
`endif
         end
         S_EXEC: begin
            case (dec_q.kind)
               K_LOAD, K_STORE: state_d = S_MEM;
               K_ALU:           state_d = S_WB;
               default: begin
                  state_d        = S_FETCH;
                  pc_wr          = 1'b1;
                  done           = 1'b1;
                  reg_wr         = dec_q.link;
                  bus.BranchType = dec_q.bt;
                  bus.JumpType   = dec_q.jt;
               end
            endcase
         end
         S_MEM: begin
            if (dec_q.kind == K_LOAD) begin
               mem_rd  = 1'b1;
               state_d = S_WB;
            end else begin
               mem_wr  = 1'b1;
               pc_wr   = 1'b1;
               done    = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_WB: begin
            reg_wr  = 1'b1;
            pc_wr   = 1'b1;
            done    = 1'b1;
            state_d = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_FETCH;
      endcase
   end

   // rst forces FETCH asynchronously, so strobes are masked to keep IRWrite quiet during reset.
   assign bus.PCWrite    = pc_wr  & ~rst;
   assign bus.IRWrite    = ir_wr  & ~rst;
   assign bus.RegWrite   = reg_wr & ~rst;
   assign bus.MemRead    = mem_rd & ~rst;
   assign bus.MemWrite   = mem_wr & ~rst;
   assign bus.instr_done = done   & ~rst;
endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-cycle comparison of the full control vector against a cycle-index model.
module tb_mc_ctrl_fsm;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   mc_ctrl_fsm_if bus ();
   mc_ctrl_fsm #(.RESET_STATE(3'd0)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   logic [25:0] obs;
   assign obs = {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.RwIdSrc, bus.RwDataSrc,
                 bus.MemRead, bus.MemWrite, bus.MemOpType, bus.MemDataExtType,
                 bus.BranchType, bus.JumpType, bus.AluCtr, bus.AluBSrc, bus.ExtType,
                 bus.instr_done, bus.illegal};

   typedef struct packed {
      logic       known;
      logic       ctl;
      logic       ld;
      logic       st;
      logic       wr;
      logic [4:0] alu;
      logic [1:0] bsrc;
      logic [1:0] rid;
      logic [1:0] rds;
      logic [1:0] jt;
      logic [2:0] bt;
      logic       ext;
      logic       mop;
      logic       mext;
   } info_t;

   // What each instruction is, as a list of properties taken from the instruction table.
   function automatic info_t info(input logic [5:0] op, input logic [5:0] fn, input logic b16);
      info_t i;
      i = '0;
      i.known = 1'b1;
      case (op)
         6'b000000: begin
            i.wr  = 1'b1;
            i.rid = 2'b01;
            case (fn)
               6'b100001: i.alu = 5'd0;
               6'b100011: i.alu = 5'd1;
               6'b100100: i.alu = 5'd2;
               6'b100101: i.alu = 5'd3;
               6'b101010: i.alu = 5'd4;
               6'b000000: i.alu = 5'd5;
               6'b001000: begin i.wr = 1'b0; i.rid = 2'b00; i.ctl = 1'b1; i.jt = 2'b11; end
               default:   i = '0;
            endcase
         end
         6'b001001: begin i.wr = 1'b1; i.bsrc = 2'b01; i.ext = 1'b1; end
         6'b001101: begin i.wr = 1'b1; i.alu = 5'd3; i.bsrc = 2'b01; end
         6'b001111: begin i.wr = 1'b1; i.alu = 5'd3; i.bsrc = 2'b11; end
         6'b100011: begin i.ld = 1'b1; i.wr = 1'b1; i.bsrc = 2'b01; i.ext = 1'b1; i.rds = 2'b01; end
         6'b100000: begin
            i.ld = 1'b1; i.wr = 1'b1; i.bsrc = 2'b01; i.ext = 1'b1; i.rds = 2'b01;
            i.mop = 1'b1; i.mext = 1'b1;
         end
         6'b101011: begin i.st = 1'b1; i.bsrc = 2'b01; i.ext = 1'b1; end
         6'b101000: begin i.st = 1'b1; i.bsrc = 2'b01; i.ext = 1'b1; i.mop = 1'b1; end
         6'b000100: begin i.ctl = 1'b1; i.alu = 5'd1; i.bt = 3'b001; end
         6'b000101: begin i.ctl = 1'b1; i.alu = 5'd1; i.bt = 3'b010; end
         6'b000001: begin i.ctl = 1'b1; i.bsrc = 2'b10; i.bt = b16 ? 3'b110 : 3'b101; end
         6'b000010: begin i.ctl = 1'b1; i.jt = 2'b01; end
         6'b000011: begin i.ctl = 1'b1; i.jt = 2'b10; i.wr = 1'b1; i.rid = 2'b10; i.rds = 2'b10; end
         default:   i.known = 1'b0;
      endcase
      return i;
   endfunction

   // Cycles to observe; a trapped instruction is watched for 20 halted cycles past DECODE.
   function automatic int lat_of(input info_t i);
      if (!i.known) return TRAP ? 22 : 3;
      if (i.ctl) return 3;
      if (i.ld) return 5;
      return 4;
   endfunction

   function automatic logic [25:0] model(input info_t i, input int c);
      logic       pcw, irw, rw, mr, mw, mop, mext, ext, done, ill;
      logic [1:0] rid, rds, jt, bsrc;
      logic [2:0] bt;
      logic [4:0] alu;
      int         lat;
      {pcw, irw, rw, mr, mw, mop, mext, ext, done, ill} = '0;
      {rid, rds, jt, bsrc, bt, alu} = '0;
      lat = lat_of(i);
      if (c == 0) begin
         irw = 1'b1;
      end else if (c >= 2) begin
         if (!i.known && TRAP) begin
            ill = 1'b1;
         end else begin
            alu = i.alu; bsrc = i.bsrc; ext = i.ext; mop = i.mop; mext = i.mext;
            rid = i.rid; rds = i.rds;
            if (c == lat - 1) begin
               pcw = 1'b1; done = 1'b1; bt = i.bt; jt = i.jt; rw = i.wr; mw = i.st;
            end
            if (i.ld && c == 3) mr = 1'b1;
         end
      end
      return {pcw, irw, rw, rid, rds, mr, mw, mop, mext, bt, jt, alu, bsrc, ext, done, ill};
   endfunction

   task automatic chk(input string tag, input logic [25:0] o, input logic [25:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, " reset_hold"}, obs, 26'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Called at a negedge while the FSM is in FETCH; the fields are live only during DECODE.
   task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic b16,
                            input string tag);
      info_t i;
      int    lat;
      i   = info(op, fn, b16);
      lat = lat_of(i);
      for (int c = 0; c < lat; c++) begin
         if (c == 1) begin
            bus.opcode = op; bus.funct = fn; bus.bit16 = b16;
         end else begin
            bus.opcode = 6'($urandom); bus.funct = 6'($urandom); bus.bit16 = 1'($urandom);
         end
         #1;
         chk($sformatf("%s c%0d", tag, c), obs, model(i, c));
         @(negedge clk);
      end
      if (!i.known && TRAP) do_reset(tag);
   endtask

   logic [5:0] op_tab [20] = '{6'b000000, 6'b000000, 6'b000000, 6'b000000, 6'b000000,
                               6'b000000, 6'b000000, 6'b001001, 6'b001101, 6'b001111,
                               6'b100011, 6'b100000, 6'b101011, 6'b101000, 6'b000100,
                               6'b000101, 6'b000001, 6'b000010, 6'b000011, 6'b000000};
   logic [5:0] fn_tab [20] = '{6'b100001, 6'b100011, 6'b100100, 6'b100101, 6'b101010,
                               6'b000000, 6'b001000, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0,
                               6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b0, 6'b111111};

   initial begin
      info_t      si;
      logic [5:0] op, fn;
      bus.opcode = '0;
      bus.funct  = '0;
      bus.bit16  = 1'b0;

      repeat (2) @(negedge clk);
      #1;
      chk("reset_state", obs, 26'd0);
      @(negedge clk);
      rst = 1'b0;

      run_instr(6'b000000, 6'b100001, 1'b0, "addu");
      run_instr(6'b100011, 6'b000000, 1'b0, "lw");
      run_instr(6'b101000, 6'b000000, 1'b0, "sb");
      run_instr(6'b000011, 6'b000000, 1'b0, "jal");
      run_instr(6'b000001, 6'b000000, 1'b1, "bgez");
      run_instr(6'b000001, 6'b000000, 1'b0, "bltz");
      run_instr(6'b000000, 6'b000000, 1'b0, "nop_sll");
      run_instr(6'b000000, 6'b001000, 1'b0, "jr");
      run_instr(6'b001111, 6'b010101, 1'b0, "lui");
      run_instr(6'b100000, 6'b000000, 1'b0, "lb");
      run_instr(6'b111111, 6'b000000, 1'b0, "illegal_op");
      run_instr(6'b000000, 6'b111110, 1'b0, "illegal_fn");
      run_instr(6'b000100, 6'b000000, 1'b0, "beq_after");

      // sw interrupted by reset during MEM: the store strobe must drop immediately.
      si = info(6'b101011, 6'b000000, 1'b0);
      for (int c = 0; c < 4; c++) begin
         bus.opcode = (c == 1) ? 6'b101011 : 6'($urandom);
         bus.funct  = 6'($urandom);
         #1;
         chk($sformatf("sw_abort c%0d", c), obs, model(si, c));
         if (c < 3) @(negedge clk);
      end
      #1;
      rst = 1'b1;
      #1;
      chk("sw_abort rst_in_mem", obs, 26'd0);
      @(negedge clk);
      rst = 1'b0;
      run_instr(6'b000000, 6'b100101, 1'b0, "or_after_abort");

      for (int n = 0; n < 60; n++) begin
         int idx;
         idx = $urandom_range(0, 19);
         op  = op_tab[idx];
         fn  = (op == 6'b000000) ? fn_tab[idx] : 6'($urandom);
         if (n % 15 == 14) op = 6'($urandom);
         run_instr(op, fn, 1'($urandom), $sformatf("rnd%0d_op%b_fn%b", n, op, fn));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
